// File: rtl/sid_reg_slave_if.sv
// sid_reg_slave_if
//   Host-bus bundle between the pin decode (master) and the SID register
//   responder (slave).
//   Master drives : wr_strobe, rd_strobe, addr[2:0], voice[1:0], wdata[7:0]
//   Slave drives  : regs_flat[NUM_VOICES*56-1:0], gate_on/gate_off[NUM_VOICES-1:0],
//                   wr_ack, rdata[7:0], rdata_oe
interface sid_reg_slave_if #(
  parameter int NUM_VOICES = 3
);
  logic                       wr_strobe;
  logic                       rd_strobe;
  logic [2:0]                 addr;
  logic [1:0]                 voice;
  logic [7:0]                 wdata;
  logic [NUM_VOICES*56-1:0]   regs_flat;
  logic [NUM_VOICES-1:0]      gate_on;
  logic [NUM_VOICES-1:0]      gate_off;
  logic                       wr_ack;
  logic [7:0]                 rdata;
  logic                       rdata_oe;

  modport master (
    output wr_strobe, rd_strobe, addr, voice, wdata,
    input  regs_flat, gate_on, gate_off, wr_ack, rdata, rdata_oe
  );

  modport slave (
    input  wr_strobe, rd_strobe, addr, voice, wdata,
    output regs_flat, gate_on, gate_off, wr_ack, rdata, rdata_oe
  );
endinterface

// File: rtl/sid_reg_slave.sv
// sid_reg_slave
//   Register-write responder for the SID host bus. Detects the rising edge of
//   the (clk-synchronous) write strobe, commits wdata into the addressed
//   per-voice register byte (or all voices for voice code 3) and emits
//   one-cycle gate_on/gate_off events when WAV bit0 changes.
//
//   Ports:
//     clk  - system clock
//     rst  - asynchronous reset, active-high
//     bus  - sid_reg_slave_if.slave: strobes/addr/voice/wdata in;
//            regs_flat, gate_on, gate_off, wr_ack, rdata, rdata_oe out
//
//   Optional feature macro: READBACK_EN
//     defined   : registered readback (rdata/rdata_oe, one-cycle latency)
//     undefined : rd_strobe ignored, rdata and rdata_oe tied low

// Per-voice register set: seven bytes plus gate-edge detection on WAV bit0.
//   we_i       - commit wdata_i to byte addr_i (addr_i 7 never arrives here)
//   regs_o     - the seven bytes, byte a at regs_o[a]
//   gate_on_o  - pulse when WAV bit0 goes 0->1
//   gate_off_o - pulse when WAV bit0 goes 1->0
//   wav0_o     - current WAV bit0 (for the readback status byte)
module sid_voice_regs (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [2:0]      addr_i,
  input  logic [7:0]      wdata_i,
  output logic [6:0][7:0] regs_o,
  output logic            gate_on_o,
  output logic            gate_off_o,
  output logic            wav0_o
);
  localparam logic [2:0] A_WAV = 3'd6;

  logic [6:0][7:0] regs_q, regs_d;
  logic            gate_on_q, gate_on_d;
  logic            gate_off_q, gate_off_d;

  always_comb begin
    regs_d     = regs_q;
    gate_on_d  = 1'b0;
    gate_off_d = 1'b0;
    if (we_i) begin
      for (int a = 0; a < 7; a++) begin
        if (addr_i == 3'(a)) regs_d[a] = wdata_i;
      end
      // Edge events compare the byte being replaced against the new one.
      if (addr_i == A_WAV) begin
        gate_on_d  = ~regs_q[A_WAV][0] &  wdata_i[0];
        gate_off_d =  regs_q[A_WAV][0] & ~wdata_i[0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      gate_on_q  <= 1'b0;
      gate_off_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      gate_on_q  <= gate_on_d;
      gate_off_q <= gate_off_d;
    end
  end

  assign regs_o     = regs_q;
  assign gate_on_o  = gate_on_q;
  assign gate_off_o = gate_off_q;
  assign wav0_o     = regs_q[A_WAV][0];
endmodule

module sid_reg_slave #(
  parameter int NUM_VOICES = 3
) (
  input  logic           clk,
  input  logic           rst,
  sid_reg_slave_if.slave bus
);
  localparam logic [1:0] V_BCAST = 2'd3;
  localparam logic [2:0] A_RSVD  = 3'd7;

  logic                             strb_q;
  logic                             wr_ack_q, wr_ack_d;
  logic                             accept;
  logic                             bcast;
  logic                             voice_valid;
  logic [NUM_VOICES-1:0]            voice_we;
  logic [NUM_VOICES-1:0][6:0][7:0]  vregs;
  logic [NUM_VOICES-1:0]            gate_on, gate_off, wav0;

  // strb_q resets to 1 so a strobe already high at reset release is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_q   <= 1'b1;
      wr_ack_q <= 1'b0;
    end else begin
      strb_q   <= bus.wr_strobe;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign accept      = bus.wr_strobe & ~strb_q;
  assign bcast       = (bus.voice == V_BCAST);
  assign voice_valid = (int'(bus.voice) < NUM_VOICES);

  // Reserved address still acks; unknown voice codes are dropped silently.
  assign wr_ack_d = accept & (bcast | voice_valid);

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign voice_we[v] = accept & (bcast | (bus.voice == 2'(v))) & (bus.addr != A_RSVD);

    sid_voice_regs u_regs (
      .clk        (clk),
      .rst        (rst),
      .we_i       (voice_we[v]),
      .addr_i     (bus.addr),
      .wdata_i    (bus.wdata),
      .regs_o     (vregs[v]),
      .gate_on_o  (gate_on[v]),
      .gate_off_o (gate_off[v]),
      .wav0_o     (wav0[v])
    );
  end

  // Packed [voice][addr][bit] flattens to voice v, addr a at (v*7+a)*8.
  assign bus.regs_flat = vregs;
  assign bus.gate_on   = gate_on;
  assign bus.gate_off  = gate_off;
  assign bus.wr_ack    = wr_ack_q;

`ifdef READBACK_EN
  logic [7:0] rdata_q, rd_sel;
  logic       rdata_oe_q;

  // Reads sample the registered bank, so a read coincident with a write to
  // the same byte sees the pre-write value.
  always_comb begin
    rd_sel = '0;
    if (voice_valid) begin
      if (bus.addr == A_RSVD) begin
        rd_sel[NUM_VOICES-1:0] = wav0;
      end else begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          for (int a = 0; a < 7; a++) begin
            if (bus.voice == 2'(v) && bus.addr == 3'(a)) rd_sel = vregs[v][a];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      rdata_oe_q <= 1'b0;
    end else begin
      rdata_oe_q <= bus.rd_strobe;
      if (bus.rd_strobe) rdata_q <= rd_sel;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rdata_oe = rdata_oe_q;
`else
  logic unused_rd;
  assign unused_rd    = &{1'b0, bus.rd_strobe, wav0};
  assign bus.rdata    = 8'h00;
  assign bus.rdata_oe = 1'b0;
`endif
endmodule

// File: tb/tb_sid_reg_slave.sv
module tb_sid_reg_slave;
  localparam int NV = 3;
  localparam int W  = NV * 56;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sid_reg_slave_if #(.NUM_VOICES(NV)) bus ();
  sid_reg_slave #(.NUM_VOICES(NV)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: plain byte array, updated once per accepted write.
  logic [7:0] m [NV][7];

  typedef struct {
    logic [1:0] v;
    logic [2:0] a;
    logic [7:0] d;
    logic [2:0] on;
    logic [2:0] off;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_flat();
    logic [W-1:0] f = '0;
    for (int u = 0; u < NV; u++)
      for (int a = 0; a < 7; a++)
        f[(u*7+a)*8 +: 8] = m[u][a];
    return f;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NV; u++)
      for (int a = 0; a < 7; a++) m[u][a] = 8'h00;
  endtask

  task automatic model_apply(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d,
                             output logic ack, output logic [2:0] on, output logic [2:0] off);
    on  = '0;
    off = '0;
    ack = (v == 2'd3) || (int'(v) < NV);
    if (ack && a != 3'd7) begin
      for (int u = 0; u < NV; u++) begin
        if (v == 2'd3 || int'(v) == u) begin
          if (a == 3'd6) begin
            on[u]  = !m[u][6][0] &&  d[0];
            off[u] =  m[u][6][0] && !d[0];
          end
          m[u][a] = d;
        end
      end
    end
  endtask

  task automatic do_write(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d,
                          input int hold, input int gap,
                          input logic ack, input logic [2:0] on, input logic [2:0] off);
    @(negedge clk);
    bus.voice = v; bus.addr = a; bus.wdata = d; bus.wr_strobe = 1'b1;
    @(negedge clk);
    chk("wr_ack", W'(bus.wr_ack), W'(ack));
    chk("gate_on", W'(bus.gate_on), W'(on));
    chk("gate_off", W'(bus.gate_off), W'(off));
    chk("regs", bus.regs_flat, model_flat());
    for (int i = 1; i < hold; i++) begin
      bus.wdata = d ^ 8'hFF;
      @(negedge clk);
      chk("wr_ack_hold", W'(bus.wr_ack), '0);
      chk("gates_hold", W'({bus.gate_on, bus.gate_off}), '0);
      chk("regs_hold", bus.regs_flat, model_flat());
    end
    bus.wr_strobe = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk("wr_ack_idle", W'(bus.wr_ack), '0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_regs"}, bus.regs_flat, '0);
    chk({nm, "_outs"}, W'({bus.gate_on, bus.gate_off, bus.wr_ack, bus.rdata, bus.rdata_oe}), '0);
  endtask

  initial begin
    logic       ack;
    logic [2:0] on, off;
    logic [1:0] rv;
    logic [2:0] ra;
    logic [7:0] rd;

    bus.wr_strobe = 1'b0; bus.rd_strobe = 1'b0;
    bus.addr = '0; bus.voice = '0; bus.wdata = '0;
    model_reset();
    #1 chk_all_zero("reset_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{2'd0, 3'd0, 8'h11, 3'b000, 3'b000};
    tbl[1] = '{2'd2, 3'd6, 8'h21, 3'b100, 3'b000};
    tbl[2] = '{2'd2, 3'd6, 8'h31, 3'b000, 3'b000};
    tbl[3] = '{2'd2, 3'd6, 8'h30, 3'b000, 3'b100};
    tbl[4] = '{2'd3, 3'd1, 8'h7F, 3'b000, 3'b000};
    tbl[5] = '{2'd0, 3'd7, 8'hFF, 3'b000, 3'b000};
    tbl[6] = '{2'd3, 3'd6, 8'h01, 3'b111, 3'b000};
    tbl[7] = '{2'd1, 3'd6, 8'h00, 3'b000, 3'b010};
    tbl[8] = '{2'd3, 3'd6, 8'hFF, 3'b010, 3'b000};
    for (int i = 0; i < 9; i++) begin
      model_apply(tbl[i].v, tbl[i].a, tbl[i].d, ack, on, off);
      do_write(tbl[i].v, tbl[i].a, tbl[i].d, 1, 1, 1'b1, tbl[i].on, tbl[i].off);
    end

    // Long strobe with data changing mid-hold: exactly one write of 0xA5.
    model_apply(2'd1, 3'd4, 8'hA5, ack, on, off);
    do_write(2'd1, 3'd4, 8'hA5, 5, 2, 1'b1, 3'b000, 3'b000);
    chk("hold_byte", W'(bus.regs_flat[(1*7+4)*8 +: 8]), W'(8'hA5));

    // Reset asserted during a write with strobe high.
    @(negedge clk);
    bus.voice = 2'd0; bus.addr = 3'd0; bus.wdata = 8'h55; bus.wr_strobe = 1'b1;
    #1 rst = 1'b1;
    #1 chk_all_zero("reset_async");
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all_zero("strobe_stuck");
    end
    bus.wr_strobe = 1'b0;
    model_apply(2'd0, 3'd0, 8'h66, ack, on, off);
    do_write(2'd0, 3'd0, 8'h66, 1, 1, 1'b1, 3'b000, 3'b000);

    // Randomized writes against the model.
    for (int i = 0; i < 40; i++) begin
      rv = 2'($urandom_range(3));
      ra = 3'($urandom_range(7));
      rd = 8'($urandom);
      if ($urandom_range(3) == 0) ra = 3'd6;
      model_apply(rv, ra, rd, ack, on, off);
      do_write(rv, ra, rd, int'($urandom_range(1, 3)), int'($urandom_range(1, 2)), ack, on, off);
    end

`ifdef READBACK_EN
    model_apply(2'd1, 3'd2, 8'h80, ack, on, off);
    do_write(2'd1, 3'd2, 8'h80, 1, 1, ack, on, off);
    model_apply(2'd1, 3'd6, 8'h41, ack, on, off);
    do_write(2'd1, 3'd6, 8'h41, 1, 1, ack, on, off);
    @(negedge clk);
    bus.rd_strobe = 1'b1; bus.voice = 2'd1; bus.addr = 3'd2;
    @(negedge clk);
    chk("rd_data", W'(bus.rdata), W'(8'h80));
    chk("rd_oe", W'(bus.rdata_oe), W'(1'b1));
    bus.addr = 3'd7;
    @(negedge clk);
    chk("rd_status", W'(bus.rdata), W'({5'b0, m[2][6][0], m[1][6][0], m[0][6][0]}));
    bus.voice = 2'd3; bus.addr = 3'd0;
    @(negedge clk);
    chk("rd_bcast", W'(bus.rdata), '0);
    // Read racing a write to the same byte returns the old value.
    bus.voice = 2'd1; bus.addr = 3'd2; bus.wdata = 8'h3C; bus.wr_strobe = 1'b1;
    @(negedge clk);
    chk("rd_prewrite", W'(bus.rdata), W'(8'h80));
    model_apply(2'd1, 3'd2, 8'h3C, ack, on, off);
    chk("wr_during_rd", bus.regs_flat, model_flat());
    bus.wr_strobe = 1'b0; bus.rd_strobe = 1'b0;
    @(negedge clk);
    chk("rd_oe_off", W'(bus.rdata_oe), '0);
`else
    @(negedge clk);
    bus.rd_strobe = 1'b1; bus.voice = 2'd1; bus.addr = 3'd2;
    @(negedge clk);
    chk("rd_tied", W'({bus.rdata, bus.rdata_oe}), '0);
    bus.rd_strobe = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sid_reg_slave.md
Name: sid_reg_slave

Overview:
Register-write responder for the SID core's host bus. It decodes the strobed addr/voice/data write protocol driven from the pins (addr 3 bits, voice 2 bits, data 8 bits, write strobe), commits bytes into a per-voice register bank and emits gate-edge events for the envelope generators. It sits between the top-level pin decode and the voice/ADSR datapath, and replaces ad-hoc register latching in the top level.

Parameters:
NUM_VOICES, 3, number of voice register sets (1..3); voice codes >= NUM_VOICES other than 3 are ignored.

Ports:
clk  input  1  system clock (5 MHz in the chip)
rst  input  1  asynchronous reset, active-high
wr_strobe  input  1  write strobe (pin ui_in[7])
addr  input  3  register address (0 FREQ_LO, 1 FREQ_HI, 2 PW_LO, 3 PW_HI, 4 ATK, 5 SUS, 6 WAV, 7 reserved)
voice  input  2  voice select; 3 = broadcast
wdata  input  8  write data
rd_strobe  input  1  read request (used only with READBACK_EN)
regs_flat  output  NUM_VOICES*56  register bank; voice v, addr a at bits [(v*7+a)*8 +: 8]
gate_on  output  NUM_VOICES  1-cycle pulse per voice on WAV bit0 0->1
gate_off  output  NUM_VOICES  1-cycle pulse per voice on WAV bit0 1->0
wr_ack  output  1  1-cycle pulse after each accepted write
rdata  output  8  readback data
rdata_oe  output  1  readback output enable

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. All state is cleared on rst assertion, with no clock required.
- Reset values: regs_flat all 0, gate_on/gate_off 0, wr_ack 0, rdata 0x00, rdata_oe 0. The internal strobe history register strb_q resets to 1.
- Write detection: strb_q <= wr_strobe every cycle. A write is accepted on the posedge where wr_strobe=1 and strb_q=0.
- addr, voice and wdata are sampled at that same posedge. Strobe is synchronous to clk; no synchronizer.
- Because strb_q resets to 1, a strobe already high when rst deasserts is ignored until it returns low.
- A strobe held high for N cycles produces exactly one write.
- Latency: the register byte updates at the accepting edge and is visible on regs_flat in the following cycle. wr_ack pulses high in that same cycle.
- voice 0..NUM_VOICES-1: write that voice only.
- voice 3: broadcast, writing all voices identically.
- Other voice codes: no register change, no gate events, no wr_ack.
- addr 7: no register change, no gate events; wr_ack still pulses.
- Gate events apply only to writes to addr 6. They compare old and new bit0 per written voice:
  - 0->1 pulses gate_on[v].
  - 1->0 pulses gate_off[v].
  - Unchanged bit0 produces no pulse.
  - Gate pulses are coincident with wr_ack.
- Other WAV bits never generate events.
- rst asserted mid-write, including strobe high: the write is lost, all outputs return to reset values, and no ack is issued.
- Back-to-back writes every 2 cycles (strobe high 1, low 1) are all accepted.

Optional Feature:
READBACK_EN
- Defined:
  - rdata_oe is registered: rdata_oe <= rd_strobe.
  - While rd_strobe=1, rdata <= the register at (voice, addr), i.e. a one-cycle read latency.
  - addr 7 returns {(8-NUM_VOICES) zeros, WAV bit0 of each voice, voice 0 in bit0}.
  - voice 3 or an invalid voice returns 0x00.
  - A read coincident with an accepted write to the same byte returns the pre-write value.
- Undefined: rd_strobe is ignored; rdata and rdata_oe are tied to 0.

Test Plan:
- Reset, then write voice0 addr0 0x11 (strobe 1 cycle) -> next cycle regs_flat[7:0]=0x11 and wr_ack high for exactly 1 cycle; all other bytes 0.
- Hold wr_strobe high 5 cycles with voice1 addr4 0xA5, then change wdata to 0x5A while still high -> byte (1,4)=0xA5, exactly one wr_ack.
- Write voice2 addr6 0x21, then 0x31, then 0x30 -> gate_on[2] pulses on the first write only, no pulse on the second, gate_off[2] pulses on the third; bytes track 0x21/0x31/0x30.
- Broadcast voice3 addr1 0x7F; separately write addr7 0xFF to voice0 -> (0..2,1)=0x7F with a single ack; the addr7 write acks and leaves regs_flat unchanged.
- Assert rst while wr_strobe=1, release with strobe still high, then drop and re-raise it -> no write until the re-raise; all outputs 0 during reset.
- READBACK_EN: write voice1 addr2 0x80 and WAV 0x41, then rd_strobe with addr2 -> one cycle later rdata=0x80, rdata_oe=1; addr7 read -> rdata=0x02.
